// File: rtl/wr_ht_budget.sv
// wr_ht_budget: HT table registers, free search and write-burst budget.
// Optional: WR_HT_BUDGET_PIPE_EN registers accum_burst_len_o.
module wr_ht_budget #(
  parameter int unsigned HtCapacity   = 8,
  parameter int unsigned MaxWrTxns    = 8,
  parameter int unsigned IdWidth      = 4,
  parameter int unsigned PrescalerDiv = 1,
  parameter int unsigned AccuCntWidth = 10,
  localparam int unsigned LdIdxWidth =
    (MaxWrTxns > 1) ? $clog2(MaxWrTxns) : 1,
  localparam int unsigned HtIdxWidth =
    (HtCapacity > 1) ? $clog2(HtCapacity) : 1,
  localparam int unsigned HtW =
    IdWidth + 2 * LdIdxWidth + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [HtCapacity*HtW-1:0]  ht_d_i,
  output logic [HtCapacity*HtW-1:0]  ht_q_o,
  output logic [HtCapacity-1:0]      ht_free_o,
  output logic [HtIdxWidth-1:0]      ht_free_idx_o,
  output logic                       ht_full_o,
  input  logic [MaxWrTxns-1:0]       ld_free_i,
  input  logic [MaxWrTxns*8-1:0]     ld_len_i,
  output logic [AccuCntWidth-1:0]    accum_burst_len_o
);

  localparam int unsigned SumW =
    9 + $clog2(MaxWrTxns) + 1;
  localparam int unsigned PsShift =
    $clog2(PrescalerDiv);
  localparam logic [HtW-1:0] HtRst =
    HtW'(1);

`ifndef SYNTHESIS
  if (PrescalerDiv == 0 ||
      (PrescalerDiv & (PrescalerDiv - 1)) != 0)
  begin : g_chk_ps
    $fatal(1, "PrescalerDiv must be a power of two");
  end
  if (HtCapacity < 1 || MaxWrTxns < 1)
  begin : g_chk_cap
    $fatal(1, "HtCapacity and MaxWrTxns must be >= 1");
  end
`endif

  logic [HtCapacity*HtW-1:0] ht_q;
  logic [HtCapacity-1:0]     ht_free;
  logic [HtIdxWidth-1:0]     free_idx;

  // manager always drives the full next state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ht_q <= {HtCapacity{HtRst}};
    end else begin
      ht_q <= ht_d_i;
    end
  end

  assign ht_q_o = ht_q;

  for (genvar i = 0; i < HtCapacity; i++)
  begin : g_free
    assign ht_free[i] = ht_q[i*HtW];
  end

  // descending scan so the lowest free index wins
  always_comb begin
    free_idx = '0;
    for (int i = int'(HtCapacity) - 1;
         i >= 0; i--) begin
      if (ht_free[i]) begin
        free_idx = HtIdxWidth'(i);
      end
    end
  end

  assign ht_free_o     = ht_free;
  assign ht_free_idx_o = free_idx;
  assign ht_full_o     = ~|ht_free;

  logic [SumW-1:0]         sum;
  logic [SumW-1:0]         prescaled;
  logic [AccuCntWidth-1:0] accum_d;

  always_comb begin
    sum = '0;
    for (int j = 0; j < int'(MaxWrTxns); j++) begin
      if (!ld_free_i[j]) begin
        sum = sum
            + SumW'(ld_len_i[j*8 +: 8])
            + SumW'(1);
      end
    end
  end

  assign prescaled = sum >> PsShift;

  if (SumW > AccuCntWidth) begin : g_sat
    assign accum_d =
      (|prescaled[SumW-1:AccuCntWidth])
        ? '1
        : prescaled[AccuCntWidth-1:0];
  end else begin : g_nosat
    assign accum_d = AccuCntWidth'(prescaled);
  end

`ifdef WR_HT_BUDGET_PIPE_EN
  logic [AccuCntWidth-1:0] accum_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      accum_q <= '0;
    end else begin
      accum_q <= accum_d;
    end
  end

  assign accum_burst_len_o = accum_q;
`else
  assign accum_burst_len_o = accum_d;
`endif

endmodule

// File: tb/tb_wr_ht_budget.sv
// tb_wr_ht_budget: vector table, hand sequences and random model check.
module tb_wr_ht_budget;

  localparam int NE  = 8;
  localparam int HTW = 11;

  logic clk;
  logic rst_n;
  logic [NE*HTW-1:0] ht_d;
  logic [NE*HTW-1:0] ht_q, ht_q4;
  logic [NE-1:0]     ht_free, ht_free4;
  logic [2:0]        idx, idx4;
  logic              full, full4;
  logic [NE-1:0]     ld_free;
  logic [NE*8-1:0]   ld_len;
  logic [9:0]        acc1, acc4;

  int n_cmp = 0;
  int n_err = 0;

  wr_ht_budget u_dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .ht_d_i            (ht_d),
    .ht_q_o            (ht_q),
    .ht_free_o         (ht_free),
    .ht_free_idx_o     (idx),
    .ht_full_o         (full),
    .ld_free_i         (ld_free),
    .ld_len_i          (ld_len),
    .accum_burst_len_o (acc1)
  );

  wr_ht_budget #(.PrescalerDiv(4)) u_dut4 (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .ht_d_i            (ht_d),
    .ht_q_o            (ht_q4),
    .ht_free_o         (ht_free4),
    .ht_free_idx_o     (idx4),
    .ht_full_o         (full4),
    .ld_free_i         (ld_free),
    .ld_len_i          (ld_len),
    .accum_burst_len_o (acc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  free;
    logic [63:0] len;
    int          e1;
    int          e4;
  } bvec_t;

  bvec_t vt[8];

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [HTW-1:0] mk(
    input int id, input int h,
    input int t, input int f);
    return {4'(id), 3'(h), 3'(t), 1'(f)};
  endfunction

  function automatic logic [NE*HTW-1:0] rst_tab();
    logic [NE*HTW-1:0] r;
    for (int i = 0; i < NE; i++)
      r[i*HTW +: HTW] = mk(0, 0, 0, 1);
    return r;
  endfunction

  // beats per occupied burst, divided, clamped
  function automatic int bud(input logic [7:0] f,
                             input logic [63:0] l,
                             input int div);
    int s = 0;
    for (int j = 0; j < NE; j++)
      if (!f[j]) s += int'(l[j*8 +: 8]) + 1;
    s = s / div;
    return (s > 1023) ? 1023 : s;
  endfunction

  task automatic apply_bud(input logic [7:0] f,
                           input logic [63:0] l,
                           input int e1,
                           input int e4,
                           input string nm);
    @(negedge clk);
    ld_free = f;
    ld_len  = l;
`ifdef WR_HT_BUDGET_PIPE_EN
    @(posedge clk);
`endif
    #1;
    chk({nm, "_div1"}, 128'(acc1), 128'(e1));
    chk({nm, "_div4"}, 128'(acc4), 128'(e4));
  endtask

  task automatic chk_ht(input logic [NE*HTW-1:0] d,
                        input string nm);
    logic [NE-1:0] ef;
    int ei;
    ef = '0;
    ei = -1;
    for (int i = 0; i < NE; i++) begin
      ef[i] = d[i*HTW];
      if (ef[i] && ei < 0) ei = i;
    end
    if (ei < 0) ei = 0;
    chk({nm, "_q"}, 128'(ht_q), 128'(d));
    chk({nm, "_free"}, 128'(ht_free), 128'(ef));
    chk({nm, "_idx"}, 128'(idx), 128'(ei));
    chk({nm, "_full"}, 128'(full), 128'(ef == 0));
  endtask

  initial begin
    logic [NE*HTW-1:0] d;
    logic [7:0]  f;
    logic [63:0] l;

    vt[0] = '{8'hFA, 64'hFFFF_FFFF_FF07_FF03, 12, 3};
    vt[1] = '{8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1023, 512};
    vt[2] = '{8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0};
    vt[3] = '{8'hFE, 64'h0000_0000_0000_0000, 1, 0};
    vt[4] = '{8'hF0, 64'hFFFF_FFFF_FFFF_FFFF, 1023, 256};
    vt[5] = '{8'hF0, 64'hFFFF_FFFF_FEFF_FFFF, 1023, 255};
    vt[6] = '{8'hF0, 64'hFFFF_FFFF_FDFF_FFFF, 1022, 255};
    vt[7] = '{8'h7F, 64'h10FF_FFFF_FFFF_FFFF, 17, 4};

    rst_n   = 1'b0;
    ht_d    = rst_tab();
    ld_free = '1;
    ld_len  = {$urandom, $urandom};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_ht(rst_tab(), "reset");
    chk("reset_acc1", 128'(acc1), 128'(0));
    chk("reset_acc4", 128'(acc4), 128'(0));

    // first three entries taken, table must not move before the edge
    @(negedge clk);
    d = rst_tab();
    d[0*HTW +: HTW] = mk(2, 1, 0, 0);
    d[1*HTW +: HTW] = mk(5, 3, 3, 0);
    d[2*HTW +: HTW] = mk(9, 6, 7, 0);
    ht_d = d;
    #1;
    chk("pre_edge_q", 128'(ht_q), 128'(rst_tab()));
    @(posedge clk);
    #1;
    chk_ht(d, "occ3");
    chk("occ3_free_lit", 128'(ht_free), 128'(8'hF8));
    @(posedge clk);
    #1;
    chk_ht(d, "hold");

    @(negedge clk);
    for (int i = 3; i < NE; i++)
      d[i*HTW +: HTW] = mk(i, i, 7 - i, 0);
    ht_d = d;
    @(posedge clk);
    #1;
    chk_ht(d, "full");
    chk("full_flag", 128'(full), 128'(1));

    @(negedge clk);
    d[7*HTW] = 1'b1;
    ht_d = d;
    @(posedge clk);
    #1;
    chk_ht(d, "top_free");
    chk("top_free_idx", 128'(idx), 128'(7));

    @(negedge clk);
    d[7*HTW] = 1'b0;
    ht_d = d;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_ht(rst_tab(), "async_rst");
    @(negedge clk);
    ht_d  = rst_tab();
    rst_n = 1'b1;

    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      for (int i = 0; i < NE; i++) begin
        int fr;
        fr = (k % 4 == 0) ? 0 :
             int'($urandom_range(0, 3) == 0);
        d[i*HTW +: HTW] = mk($urandom_range(0, 15),
                             $urandom_range(0, 7),
                             $urandom_range(0, 7), fr);
      end
      ht_d = d;
      @(posedge clk);
      #1;
      chk_ht(d, $sformatf("ht_rand%0d", k));
    end

    for (int v = 0; v < 8; v++)
      apply_bud(vt[v].free, vt[v].len,
                vt[v].e1, vt[v].e4,
                $sformatf("vec%0d", v));

    @(negedge clk);
    ld_free = '1;
    ld_len  = '0;
    @(posedge clk);
    #1;
    chk("lat_idle", 128'(acc1), 128'(0));
    @(negedge clk);
    ld_free = 8'hFE;
    #1;
`ifdef WR_HT_BUDGET_PIPE_EN
    chk("lat_same", 128'(acc1), 128'(0));
`else
    chk("lat_same", 128'(acc1), 128'(1));
`endif
    @(posedge clk);
    #1;
    chk("lat_next", 128'(acc1), 128'(1));

    for (int k = 0; k < 150; k++) begin
      f = 8'($urandom);
      if (k % 5 == 0) f = 8'h00;
      l = {$urandom, $urandom};
      if (k % 7 == 0) l = '1;
      apply_bud(f, l, bud(f, l, 1), bud(f, l, 4),
                $sformatf("bud_rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
